// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, decode-select helper and D->E bubble values.
// Pure constants and functions; no state, no latency.
// No flow control; consumed by the decode stage and its register file.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register identifiers
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Non-data fields loaded into E on reset or bubble (data fields clear to zero)
  localparam logic [3:0] BUB_ICODE  = INOP;
  localparam logic [3:0] BUB_IFUN   = 4'h0;
  localparam logic [2:0] BUB_STAT   = SAOK;
  localparam logic [3:0] BUB_REG    = RNONE;
  localparam logic       BUB_BRANCH = 1'b0;

  // Register selection produced by decode
  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_sel_t;

  function automatic dec_sel_t decode_sel(input logic [3:0] icode,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb);
    dec_sel_t s;
    s = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      IRRMOVQ: begin s.src_a = ra;  s.dst_e = rb; end
      IIRMOVQ: begin s.dst_e = rb; end
      IRMMOVQ: begin s.src_a = ra;  s.src_b = rb; end
      IMRMOVQ: begin s.src_b = rb;  s.dst_m = ra; end
      IOPQ:    begin s.src_a = ra;  s.src_b = rb; s.dst_e = rb; end
      ICALL:   begin s.src_b = RSP; s.dst_e = RSP; end
      IRET:    begin s.src_a = RSP; s.src_b = RSP; s.dst_e = RSP; end
      IPUSHQ:  begin s.src_a = ra;  s.src_b = RSP; s.dst_e = RSP; end
      IPOPQ:   begin s.src_a = RSP; s.src_b = RSP; s.dst_e = RSP; s.dst_m = ra; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/y86_decode_stage_if.sv
// D->E pipeline-register bus from the decode stage to execute.
// Registered fields; valid one cycle after decode inputs.
// No handshake; hazard control holds or bubbles the producer.
interface y86_decode_stage_if #(parameter int DATA_W = 64);

  logic [DATA_W-1:0] E_PC_o;
  logic [DATA_W-1:0] E_valC_o;
  logic [DATA_W-1:0] E_valA_o;
  logic [DATA_W-1:0] E_valB_o;
  logic [2:0]        E_stat_o;
  logic [3:0]        E_icode_o;
  logic [3:0]        E_ifun_o;
  logic [3:0]        E_dstE_o;
  logic [3:0]        E_dstM_o;
  logic [3:0]        E_srcA_o;
  logic [3:0]        E_srcB_o;
  logic              E_branch_taken_o;

  modport master (
    output E_PC_o, E_valC_o, E_valA_o, E_valB_o, E_stat_o, E_icode_o, E_ifun_o,
           E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o, E_branch_taken_o
  );

  modport slave (
    input  E_PC_o, E_valC_o, E_valA_o, E_valB_o, E_stat_o, E_icode_o, E_ifun_o,
           E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o, E_branch_taken_o
  );

endinterface

// File: rtl/y86_regfile.sv
// 15-entry register file, two combinational reads, two writes per cycle.
// Reads are zero-latency and see pre-edge contents; writes land on posedge.
// No backpressure. Optional debug read port under DECODE_DBG_PORT_EN.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] wval_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] wval_m
`ifdef DECODE_DBG_PORT_EN
  ,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  logic [DATA_W-1:0] regs [15];

  // Synchronous clear; the M write is issued last so it wins a shared destination
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= wval_e;
      if (dst_m != RNONE) regs[dst_m] <= wval_m;
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

`ifdef DECODE_DBG_PORT_EN
  assign dbg_data = (dbg_addr == RNONE) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 F predicted-PC register, decode with E/M/W forwarding, and D->E register.
// F and E registers update one cycle after their inputs; decode is combinational.
// Driven by hazard control: F_stall_i, E_stall_i, E_bubble_i. DECODE_DBG_PORT_EN adds a debug read.
module y86_decode_stage
  import y86_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              F_stall_i,
  input  logic [DATA_W-1:0] f_predPC_i,
  output logic [DATA_W-1:0] F_predPC_o,
  input  logic [DATA_W-1:0] D_PC_i,
  input  logic [DATA_W-1:0] D_valC_i,
  input  logic [DATA_W-1:0] D_valP_i,
  input  logic [2:0]        D_stat_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_ifun_i,
  input  logic [3:0]        D_rA_i,
  input  logic [3:0]        D_rB_i,
  input  logic              D_branch_taken_i,
  input  logic [3:0]        e_dstE_i,
  input  logic [3:0]        M_dstE_i,
  input  logic [3:0]        M_dstM_i,
  input  logic [3:0]        W_dstE_i,
  input  logic [3:0]        W_dstM_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic              E_stall_i,
  input  logic              E_bubble_i,
  output logic [3:0]        d_srcA_o,
  output logic [3:0]        d_srcB_o,
`ifdef DECODE_DBG_PORT_EN
  input  logic [3:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
`endif
  y86_decode_stage_if.master e_bus
);

  dec_sel_t          sel;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;

  assign sel      = decode_sel(D_icode_i, D_rA_i, D_rB_i);
  assign d_srcA_o = sel.src_a;
  assign d_srcB_o = sel.src_b;

  y86_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .src_a  (sel.src_a),
    .src_b  (sel.src_b),
    .val_a  (rf_a),
    .val_b  (rf_b),
    .dst_e  (W_dstE_i),
    .wval_e (W_valE_i),
    .dst_m  (W_dstM_i),
    .wval_m (W_valM_i)
`ifdef DECODE_DBG_PORT_EN
    ,
    .dbg_addr (dbg_addr_i),
    .dbg_data (dbg_data_o)
`endif
  );

  // Predicted-PC register: hold on stall
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)        F_predPC_o <= RESET_PC;
    else if (!F_stall_i) F_predPC_o <= f_predPC_i;
  end

  // Operand selection: valP for jump/call, else youngest matching producer, else register file
  always_comb begin
    d_valA = rf_a;
    d_valB = rf_b;
    if (D_icode_i == ICALL || D_icode_i == IJXX) d_valA = D_valP_i;
    else if (sel.src_a == RNONE)                 d_valA = '0;
    else if (sel.src_a == e_dstE_i)              d_valA = e_valE_i;
    else if (sel.src_a == M_dstM_i)              d_valA = m_valM_i;
    else if (sel.src_a == M_dstE_i)              d_valA = M_valE_i;
    else if (sel.src_a == W_dstM_i)              d_valA = W_valM_i;
    else if (sel.src_a == W_dstE_i)              d_valA = W_valE_i;

    if (sel.src_b == RNONE)         d_valB = '0;
    else if (sel.src_b == e_dstE_i) d_valB = e_valE_i;
    else if (sel.src_b == M_dstM_i) d_valB = m_valM_i;
    else if (sel.src_b == M_dstE_i) d_valB = M_valE_i;
    else if (sel.src_b == W_dstM_i) d_valB = W_valM_i;
    else if (sel.src_b == W_dstE_i) d_valB = W_valE_i;
  end

  // D->E register: reset/bubble inject a NOP, stall holds, otherwise load decode results
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || E_bubble_i) begin
      e_bus.E_PC_o           <= '0;
      e_bus.E_valC_o         <= '0;
      e_bus.E_valA_o         <= '0;
      e_bus.E_valB_o         <= '0;
      e_bus.E_stat_o         <= BUB_STAT;
      e_bus.E_icode_o        <= BUB_ICODE;
      e_bus.E_ifun_o         <= BUB_IFUN;
      e_bus.E_dstE_o         <= BUB_REG;
      e_bus.E_dstM_o         <= BUB_REG;
      e_bus.E_srcA_o         <= BUB_REG;
      e_bus.E_srcB_o         <= BUB_REG;
      e_bus.E_branch_taken_o <= BUB_BRANCH;
    end else if (!E_stall_i) begin
      e_bus.E_PC_o           <= D_PC_i;
      e_bus.E_valC_o         <= D_valC_i;
      e_bus.E_valA_o         <= d_valA;
      e_bus.E_valB_o         <= d_valB;
      e_bus.E_stat_o         <= D_stat_i;
      e_bus.E_icode_o        <= D_icode_i;
      e_bus.E_ifun_o         <= D_ifun_i;
      e_bus.E_dstE_o         <= sel.dst_e;
      e_bus.E_dstM_o         <= sel.dst_m;
      e_bus.E_srcA_o         <= sel.src_a;
      e_bus.E_srcB_o         <= sel.src_b;
      e_bus.E_branch_taken_o <= D_branch_taken_i;
    end
  end

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed bench for y86_decode_stage: vector table plus multi-cycle sequences.
// Inputs driven on negedge; outputs sampled 1 time unit after posedge.
// Builds with or without DECODE_DBG_PORT_EN.
module tb_y86_decode_stage;
  import y86_pkg::*;

  localparam logic [3:0]  N = 4'hF;
  localparam logic [63:0] Z = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        F_stall = 1'b0;
  logic [63:0] f_predPC = '0;
  logic [63:0] F_predPC;
  logic [63:0] D_PC = '0, D_valC = '0, D_valP = '0;
  logic [2:0]  D_stat = SAOK;
  logic [3:0]  D_icode = INOP, D_ifun = '0, D_rA = N, D_rB = N;
  logic        D_branch = 1'b0;
  logic [3:0]  e_dstE = N, M_dstE = N, M_dstM = N, W_dstE = N, W_dstM = N;
  logic [63:0] e_valE = '0, M_valE = '0, m_valM = '0, W_valE = '0, W_valM = '0;
  logic        E_stall = 1'b0, E_bubble = 1'b0;
  logic [3:0]  d_srcA, d_srcB;
`ifdef DECODE_DBG_PORT_EN
  logic [3:0]  dbg_addr = N;
  logic [63:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  y86_decode_stage_if #(.DATA_W(64)) e_bus ();

  y86_decode_stage #(.DATA_W(64), .RESET_PC(64'h0)) dut (
    .clk_i (clk), .rst_n_i (rst_n),
    .F_stall_i (F_stall), .f_predPC_i (f_predPC), .F_predPC_o (F_predPC),
    .D_PC_i (D_PC), .D_valC_i (D_valC), .D_valP_i (D_valP), .D_stat_i (D_stat),
    .D_icode_i (D_icode), .D_ifun_i (D_ifun), .D_rA_i (D_rA), .D_rB_i (D_rB),
    .D_branch_taken_i (D_branch),
    .e_dstE_i (e_dstE), .M_dstE_i (M_dstE), .M_dstM_i (M_dstM), .W_dstE_i (W_dstE), .W_dstM_i (W_dstM),
    .e_valE_i (e_valE), .M_valE_i (M_valE), .m_valM_i (m_valM), .W_valE_i (W_valE), .W_valM_i (W_valM),
    .E_stall_i (E_stall), .E_bubble_i (E_bubble),
    .d_srcA_o (d_srcA), .d_srcB_o (d_srcB),
`ifdef DECODE_DBG_PORT_EN
    .dbg_addr_i (dbg_addr), .dbg_data_o (dbg_data),
`endif
    .e_bus (e_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ra, rb;
    logic [63:0] valp;
    logic [3:0]  ed;  logic [63:0] ev;
    logic [3:0]  mmd; logic [63:0] mmv;
    logic [3:0]  med; logic [63:0] mev;
    logic [3:0]  wmd; logic [63:0] wmv;
    logic [3:0]  wed; logic [63:0] wev;
    logic [3:0]  xsa, xsb, xde, xdm;
    logic [63:0] xva, xvb;
  } vec_t;

  function automatic vec_t mk(
    input logic [3:0] icode, ra, rb, input logic [63:0] valp,
    input logic [3:0] ed, input logic [63:0] ev, input logic [3:0] mmd, input logic [63:0] mmv,
    input logic [3:0] med, input logic [63:0] mev, input logic [3:0] wmd, input logic [63:0] wmv,
    input logic [3:0] wed, input logic [63:0] wev,
    input logic [3:0] xsa, xsb, xde, xdm, input logic [63:0] xva, xvb);
    vec_t v;
    v.icode = icode; v.ra = ra; v.rb = rb; v.valp = valp;
    v.ed = ed; v.ev = ev; v.mmd = mmd; v.mmv = mmv; v.med = med; v.mev = mev;
    v.wmd = wmd; v.wmv = wmv; v.wed = wed; v.wev = wev;
    v.xsa = xsa; v.xsb = xsb; v.xde = xde; v.xdm = xdm; v.xva = xva; v.xvb = xvb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_fwd();
    e_dstE = N; M_dstE = N; M_dstM = N; W_dstE = N; W_dstM = N;
    e_valE = Z; M_valE = Z; m_valM = Z; W_valE = Z; W_valM = Z;
  endtask

  task automatic set_d(input logic [3:0] icode, ra, rb, input logic [63:0] valp);
    D_icode = icode; D_rA = ra; D_rB = rb; D_valP = valp;
  endtask

  // One clock: edge then settle; caller drives at negedge beforehand
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  logic [63:0] last_pc;

  initial begin
    // Reg state entering the table: r3=0x55, all others 0
    tbl.push_back(mk(IOPQ,   4'h2, 4'h5, Z,      4'h2, 64'h11, 4'h2, 64'h22, N, Z, N, Z, 4'h2, 64'h33, 4'h2, 4'h5, 4'h5, N, 64'h11, Z));
    tbl.push_back(mk(IOPQ,   4'h2, 4'h3, Z,      N, Z, 4'h2, 64'h22, 4'h2, 64'h44, N, Z, 4'h2, 64'h33, 4'h2, 4'h3, 4'h3, N, 64'h22, 64'h55));
    tbl.push_back(mk(IOPQ,   4'h2, 4'h2, Z,      N, Z, N, Z, 4'h2, 64'h44, 4'h2, 64'h66, 4'h2, 64'h33, 4'h2, 4'h2, 4'h2, N, 64'h44, 64'h44));
    tbl.push_back(mk(IOPQ,   4'h2, 4'h6, Z,      N, Z, N, Z, N, Z, 4'h2, 64'h77, 4'h2, 64'h33, 4'h2, 4'h6, 4'h6, N, 64'h77, Z));
    tbl.push_back(mk(IOPQ,   4'h2, 4'h7, Z,      N, Z, N, Z, N, Z, N, Z, 4'h7, 64'h99, 4'h2, 4'h7, 4'h7, N, 64'h77, 64'h99));
    tbl.push_back(mk(ICALL,  N,    N,    64'h40, 4'h4, 64'h88, N, Z, N, Z, N, Z, N, Z, N, RSP, RSP, N, 64'h40, 64'h88));
    tbl.push_back(mk(IJXX,   N,    N,    64'h80, N, 64'hDEAD, N, Z, N, Z, N, Z, N, Z, N, N, N, N, 64'h80, Z));
    tbl.push_back(mk(IMRMOVQ,4'h6, 4'h7, 64'h5,  N, Z, N, Z, N, Z, N, Z, N, Z, N, 4'h7, N, 4'h6, Z, 64'h99));
    tbl.push_back(mk(IPOPQ,  4'h1, N,    Z,      N, Z, N, Z, 4'h4, 64'h200, N, Z, N, Z, RSP, RSP, RSP, 4'h1, 64'h200, 64'h200));
    tbl.push_back(mk(IRMMOVQ,4'h3, 4'h2, Z,      N, Z, N, Z, N, Z, N, Z, N, Z, 4'h3, 4'h2, N, N, 64'h55, 64'h77));
    tbl.push_back(mk(IIRMOVQ,N,    4'h9, Z,      N, Z, N, Z, N, Z, N, Z, N, Z, N, N, 4'h9, N, Z, Z));
    tbl.push_back(mk(IRRMOVQ,4'h7, 4'h1, Z,      N, Z, N, Z, N, Z, N, Z, N, Z, 4'h7, N, 4'h1, N, 64'h99, Z));
    tbl.push_back(mk(IRET,   N,    N,    Z,      N, Z, N, Z, N, Z, N, Z, N, Z, RSP, RSP, RSP, N, Z, Z));
    tbl.push_back(mk(IHALT,  4'h3, 4'h3, Z,      N, Z, N, Z, N, Z, N, Z, N, Z, N, N, N, N, Z, Z));
    tbl.push_back(mk(IPUSHQ, 4'h3, N,    Z,      N, Z, N, Z, N, Z, N, Z, N, Z, 4'h3, RSP, RSP, N, 64'h55, Z));

    // Reset: one edge with rst_n low
    rst_n = 1'b0;
    tick();
    chk("rst_predpc", F_predPC, 64'h0);
    chk("rst_icode", {60'h0, e_bus.E_icode_o}, {60'h0, INOP});
    chk("rst_stat", {61'h0, e_bus.E_stat_o}, {61'h0, SAOK});
    chk("rst_dstE", {60'h0, e_bus.E_dstE_o}, {60'h0, N});
    chk("rst_srcA", {60'h0, e_bus.E_srcA_o}, {60'h0, N});
    @(negedge clk);
    rst_n = 1'b1;
    F_stall = 1'b1;

    // All registers read back zero after reset
    for (int r = 0; r < 15; r += 2) begin
      set_d(IOPQ, 4'(r), 4'(r + 1), Z);
      tick();
      chk($sformatf("rst_reg%0d", r), e_bus.E_valA_o, Z);
      chk($sformatf("rst_reg%0d", r + 1), e_bus.E_valB_o, Z);
      @(negedge clk);
    end

    // Writeback r3 then read it without forwarding
    set_d(INOP, N, N, Z);
    W_dstE = 4'h3; W_valE = 64'h55;
    tick();
    @(negedge clk);
    clear_fwd();
    set_d(IOPQ, 4'h3, 4'h3, Z);
    tick();
    chk("wb_valA", e_bus.E_valA_o, 64'h55);
    chk("wb_valB", e_bus.E_valB_o, 64'h55);
    @(negedge clk);

    // Table: decode selection, forwarding priority and pass-through fields
    foreach (tbl[i]) begin
      set_d(tbl[i].icode, tbl[i].ra, tbl[i].rb, tbl[i].valp);
      D_ifun = 4'(i); D_PC = 64'h1000 + 64'(i) * 8; D_valC = 64'hC000 + 64'(i);
      D_stat = 3'((i % 4) + 1); D_branch = i[0];
      e_dstE = tbl[i].ed;  e_valE = tbl[i].ev;
      M_dstM = tbl[i].mmd; m_valM = tbl[i].mmv;
      M_dstE = tbl[i].med; M_valE = tbl[i].mev;
      W_dstM = tbl[i].wmd; W_valM = tbl[i].wmv;
      W_dstE = tbl[i].wed; W_valE = tbl[i].wev;
      #1;
      chk($sformatf("v%0d_d_srcA", i), {60'h0, d_srcA}, {60'h0, tbl[i].xsa});
      chk($sformatf("v%0d_d_srcB", i), {60'h0, d_srcB}, {60'h0, tbl[i].xsb});
      tick();
      chk($sformatf("v%0d_valA", i), e_bus.E_valA_o, tbl[i].xva);
      chk($sformatf("v%0d_valB", i), e_bus.E_valB_o, tbl[i].xvb);
      chk($sformatf("v%0d_regs", i),
          {48'h0, e_bus.E_srcA_o, e_bus.E_srcB_o, e_bus.E_dstE_o, e_bus.E_dstM_o},
          {48'h0, tbl[i].xsa, tbl[i].xsb, tbl[i].xde, tbl[i].xdm});
      chk($sformatf("v%0d_ctl", i),
          {52'h0, e_bus.E_icode_o, e_bus.E_ifun_o, e_bus.E_stat_o, e_bus.E_branch_taken_o},
          {52'h0, tbl[i].icode, 4'(i), 3'((i % 4) + 1), i[0]});
      chk($sformatf("v%0d_pc", i), e_bus.E_PC_o, 64'h1000 + 64'(i) * 8);
      chk($sformatf("v%0d_valC", i), e_bus.E_valC_o, 64'hC000 + 64'(i));
      @(negedge clk);
    end
    last_pc = 64'h1000 + 64'(tbl.size() - 1) * 8;

    // E stall: fields from the last PUSHQ stay put while D changes
    clear_fwd();
    E_stall = 1'b1;
    set_d(IOPQ, 4'h7, 4'h7, Z); D_PC = 64'hBEEF;
    tick();
    chk("stall_icode", {60'h0, e_bus.E_icode_o}, {60'h0, IPUSHQ});
    chk("stall_valA", e_bus.E_valA_o, 64'h55);
    chk("stall_pc", e_bus.E_PC_o, last_pc);
    @(negedge clk);

    // Bubble overrides stall
    E_bubble = 1'b1;
    tick();
    chk("bub_icode", {60'h0, e_bus.E_icode_o}, {60'h0, INOP});
    chk("bub_stat", {61'h0, e_bus.E_stat_o}, {61'h0, SAOK});
    chk("bub_valA", e_bus.E_valA_o, Z);
    chk("bub_pc", e_bus.E_PC_o, Z);
    chk("bub_regs", {48'h0, e_bus.E_srcA_o, e_bus.E_srcB_o, e_bus.E_dstE_o, e_bus.E_dstM_o}, {48'h0, 16'hFFFF});
    @(negedge clk);
    E_bubble = 1'b0; E_stall = 1'b0;

    // F register: load, hold under stall, then load again
    F_stall = 1'b0; f_predPC = 64'h20;
    tick();
    chk("f_load", F_predPC, 64'h20);
    @(negedge clk);
    F_stall = 1'b1; f_predPC = 64'h100;
    tick();
    chk("f_stall", F_predPC, 64'h20);
    @(negedge clk);
    F_stall = 1'b0;
    tick();
    chk("f_release", F_predPC, 64'h100);
    @(negedge clk);

    // Same-destination writeback: valM wins
    set_d(INOP, N, N, Z);
    W_dstE = 4'h4; W_valE = 64'h1; W_dstM = 4'h4; W_valM = 64'h2;
    tick();
    @(negedge clk);
    clear_fwd();
    set_d(IOPQ, 4'h4, 4'h3, Z);
    tick();
    chk("samedst_reg4", e_bus.E_valA_o, 64'h2);
    chk("pre_rst_reg3", e_bus.E_valB_o, 64'h55);
    @(negedge clk);

    // Mid-run reset clears the register file
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    set_d(IOPQ, 4'h4, 4'h3, Z);
    tick();
    chk("rerst_reg4", e_bus.E_valA_o, Z);
    chk("rerst_reg3", e_bus.E_valB_o, Z);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
